// File: rtl/decode_pkg.sv
/*------------------------------------------------------------------------------
 * Module      : decode_pkg
 * Description : Opcodes, FSM state encoding and instruction field positions
 *               shared by the decode/execute block.
 * Revision    : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

package decode_pkg;

  localparam int OPC_W = 8;

  localparam logic [OPC_W-1:0] OPC_NOP  = 8'h00;
  localparam logic [OPC_W-1:0] OPC_MOVB = 8'h01;
  localparam logic [OPC_W-1:0] OPC_ADD  = 8'h02;
  localparam logic [OPC_W-1:0] OPC_SUB  = 8'h03;
  localparam logic [OPC_W-1:0] OPC_INC  = 8'h04;
  localparam logic [OPC_W-1:0] OPC_DEC  = 8'h05;
  localparam logic [OPC_W-1:0] OPC_LDI  = 8'h18;
  localparam logic [OPC_W-1:0] OPC_HALT = 8'hFF;

  // Byte lanes of the default 32-bit instruction word; [7:0] carries nothing.
  localparam int BYTE0_MSB = 31;
  localparam int BYTE0_LSB = 24;
  localparam int BYTE1_MSB = 23;
  localparam int BYTE1_LSB = 16;
  localparam int BYTE2_MSB = 15;
  localparam int BYTE2_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_ACK      = 3'd2,
    ST_WAIT_LOW = 3'd3,
    ST_HALTED   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/decode_alu.sv
/*------------------------------------------------------------------------------
 * Module      : decode_alu
 * Description : Combinational opcode decode and execute on the A/B pair.
 * Revision    : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module decode_alu #(
  parameter int          DATA_WIDTH = 16,
  parameter logic [7:0]  OPC_LDI    = 8'h18
) (
  input  logic [7:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  zero_in,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  zero_out,
  output logic                  carry_out,
  output logic                  illegal,
  output logic                  halt
);
  import decode_pkg::*;

  localparam logic [DATA_WIDTH:0] c_one = {{DATA_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH:0] w_ext;
  logic                w_arith;

  always_comb begin
    a_out     = a_in;
    b_out     = b_in;
    zero_out  = zero_in;
    carry_out = carry_in;
    illegal   = 1'b0;
    halt      = 1'b0;
    w_ext     = '0;
    w_arith   = 1'b0;

    if (opcode == OPC_LDI) begin
      a_out = imm;
    end else begin
      // The extra MSB of w_ext is the carry out, or the borrow for subtraction.
      case (opcode)
        OPC_NOP:  ;
        OPC_MOVB: b_out = a_in;
        OPC_ADD: begin
          w_ext   = {1'b0, a_in} + {1'b0, b_in};
          w_arith = 1'b1;
        end
        OPC_SUB: begin
          w_ext   = {1'b0, a_in} - {1'b0, b_in};
          w_arith = 1'b1;
        end
        OPC_INC: begin
          w_ext   = {1'b0, a_in} + c_one;
          w_arith = 1'b1;
        end
        OPC_DEC: begin
          w_ext   = {1'b0, a_in} - c_one;
          w_arith = 1'b1;
        end
        OPC_HALT: halt    = 1'b1;
        default:  illegal = 1'b1;
      endcase
    end

    if (w_arith) begin
      a_out     = w_ext[DATA_WIDTH-1:0];
      carry_out = w_ext[DATA_WIDTH];
      zero_out  = (w_ext[DATA_WIDTH-1:0] == '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_decode_exec.sv
/*------------------------------------------------------------------------------
 * Module      : instr_decode_exec
 * Description : Captures a fetched instruction word, executes it on the A/B
 *               register pair and acknowledges the fetcher with a ready pulse.
 * Revision    : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module instr_decode_exec #(
  parameter int         INSTR_WIDTH = 32,
  parameter int         DATA_WIDTH  = 16,
  parameter int         COUNT_WIDTH = 16,
  parameter logic [7:0] OPC_LDI     = 8'h18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   ready,
  output logic [DATA_WIDTH-1:0]  acc,
  output logic [DATA_WIDTH-1:0]  breg,
  output logic                   zero,
  output logic                   carry,
  output logic                   illegal,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired
);
  import decode_pkg::*;

  localparam int c_imm_lsb = INSTR_WIDTH - 8 - DATA_WIDTH;

  state_t                  r_state,   w_state_nxt;
  logic [7:0]              r_opcode,  w_opcode_nxt;
  logic [DATA_WIDTH-1:0]   r_imm,     w_imm_nxt;
  logic [DATA_WIDTH-1:0]   r_acc,     w_acc_nxt;
  logic [DATA_WIDTH-1:0]   r_breg,    w_breg_nxt;
  logic                    r_zero,    w_zero_nxt;
  logic                    r_carry,   w_carry_nxt;
  logic                    r_illegal, w_illegal_nxt;
  logic                    r_halted,  w_halted_nxt;
  logic                    r_ready,   w_ready_nxt;
  logic [COUNT_WIDTH-1:0]  r_retired, w_retired_nxt;

  logic [DATA_WIDTH-1:0]   w_alu_a;
  logic [DATA_WIDTH-1:0]   w_alu_b;
  logic                    w_alu_zero;
  logic                    w_alu_carry;
  logic                    w_alu_illegal;
  logic                    w_alu_halt;

  // Trailing instruction bits never influence execution.
  logic                    w_unused_low;
  assign w_unused_low = ^instr[c_imm_lsb-1:0];

  decode_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .OPC_LDI    (OPC_LDI)
  ) u_alu (
    .opcode    (r_opcode),
    .a_in      (r_acc),
    .b_in      (r_breg),
    .imm       (r_imm),
    .zero_in   (r_zero),
    .carry_in  (r_carry),
    .a_out     (w_alu_a),
    .b_out     (w_alu_b),
    .zero_out  (w_alu_zero),
    .carry_out (w_alu_carry),
    .illegal   (w_alu_illegal),
    .halt      (w_alu_halt)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_opcode_nxt  = r_opcode;
    w_imm_nxt     = r_imm;
    w_acc_nxt     = r_acc;
    w_breg_nxt    = r_breg;
    w_zero_nxt    = r_zero;
    w_carry_nxt   = r_carry;
    w_illegal_nxt = r_illegal;
    w_halted_nxt  = r_halted;
    w_ready_nxt   = 1'b0;
    w_retired_nxt = r_retired;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_opcode_nxt = instr[INSTR_WIDTH-1 -: 8];
          w_imm_nxt    = instr[INSTR_WIDTH-9 -: DATA_WIDTH];
          w_state_nxt  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_acc_nxt     = w_alu_a;
        w_breg_nxt    = w_alu_b;
        w_zero_nxt    = w_alu_zero;
        w_carry_nxt   = w_alu_carry;
        w_illegal_nxt = r_illegal | w_alu_illegal;
        w_halted_nxt  = r_halted | w_alu_halt;
        w_ready_nxt   = 1'b1;
        w_state_nxt   = ST_ACK;
      end
      ST_ACK: begin
        w_retired_nxt = r_retired + COUNT_WIDTH'(1);
        w_state_nxt   = r_halted ? ST_HALTED : ST_WAIT_LOW;
      end
      // The fetcher still drives start for one edge after seeing ready.
      ST_WAIT_LOW: begin
        if (!start) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_opcode  <= '0;
      r_imm     <= '0;
      r_acc     <= '0;
      r_breg    <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
      r_halted  <= 1'b0;
      r_ready   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_opcode  <= w_opcode_nxt;
      r_imm     <= w_imm_nxt;
      r_acc     <= w_acc_nxt;
      r_breg    <= w_breg_nxt;
      r_zero    <= w_zero_nxt;
      r_carry   <= w_carry_nxt;
      r_illegal <= w_illegal_nxt;
      r_halted  <= w_halted_nxt;
      r_ready   <= w_ready_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  assign ready   = r_ready;
  assign acc     = r_acc;
  assign breg    = r_breg;
  assign zero    = r_zero;
  assign carry   = r_carry;
  assign illegal = r_illegal;
  assign halted  = r_halted;
  assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_exec.sv
/*------------------------------------------------------------------------------
 * Module      : tb_instr_decode_exec
 * Description : Self-checking bench for instr_decode_exec.
 * Revision    : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_instr_decode_exec;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] instr;
  logic        ready;
  logic [15:0] acc;
  logic [15:0] breg;
  logic        zero;
  logic        carry;
  logic        illegal;
  logic        halted;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, kept as plain integers.
  int m_acc, m_breg, m_zero, m_carry, m_illegal, m_halted, m_retired;

  typedef struct {
    logic [31:0] word;
    logic [15:0] exp_acc;
    logic [15:0] exp_breg;
    logic        exp_zero;
    logic        exp_carry;
    logic        exp_illegal;
  } vec_t;

  vec_t tbl [18];

  instr_decode_exec dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .instr   (instr),
    .ready   (ready),
    .acc     (acc),
    .breg    (breg),
    .zero    (zero),
    .carry   (carry),
    .illegal (illegal),
    .halted  (halted),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_breg = 0; m_zero = 0; m_carry = 0;
    m_illegal = 0; m_halted = 0; m_retired = 0;
  endtask

  task automatic model_step(input logic [31:0] w);
    logic [7:0] op;
    int         imm;
    int         s;
    op  = w[31:24];
    imm = int'(w[23:8]);
    case (op)
      8'h18: m_acc = imm;
      8'h00: ;
      8'h01: m_breg = m_acc;
      8'h02: begin
        s = m_acc + m_breg;
        m_carry = (s > 65535);
        m_acc = s % 65536;
        m_zero = (m_acc == 0);
      end
      8'h03: begin
        m_carry = (m_acc < m_breg);
        m_acc = (m_acc - m_breg + 65536) % 65536;
        m_zero = (m_acc == 0);
      end
      8'h04: begin
        m_carry = (m_acc == 65535);
        m_acc = (m_acc + 1) % 65536;
        m_zero = (m_acc == 0);
      end
      8'h05: begin
        m_carry = (m_acc == 0);
        m_acc = (m_acc + 65535) % 65536;
        m_zero = (m_acc == 0);
      end
      8'hFF: m_halted = 1;
      default: m_illegal = 1;
    endcase
    m_retired = (m_retired + 1) % 65536;
  endtask

  task automatic compare_all(input string tag);
    check($sformatf("%s acc", tag),     acc,     m_acc);
    check($sformatf("%s breg", tag),    breg,    m_breg);
    check($sformatf("%s zero", tag),    zero,    m_zero);
    check($sformatf("%s carry", tag),   carry,   m_carry);
    check($sformatf("%s illegal", tag), illegal, m_illegal);
    check($sformatf("%s halted", tag),  halted,  m_halted);
    check($sformatf("%s retired", tag), retired, m_retired);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; start = 1'b0; instr = '0;
    @(posedge clk); #1;
    model_reset();
    compare_all("reset");
    check("reset ready", ready, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One fetcher handshake; instr is scrambled once captured.
  task automatic run_instr(input logic [31:0] w, output logic [15:0] acc_ack);
    @(negedge clk);
    start = 1'b1; instr = w;
    @(posedge clk); #1;
    check("ready during exec", ready, 0);
    instr = $urandom;
    @(posedge clk); #1;
    check("ready at ack", ready, 1);
    acc_ack = acc;
    @(posedge clk); #1;
    check("ready after ack", ready, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] acc_ack;
    logic [31:0] w;
    logic [7:0]  op;
    logic [15:0] imm;
    int          pulses;
    int          r;
    int          ret_before;

    reset = 1'b0; start = 1'b0; instr = '0;
    tbl[0]  = '{32'h18123400, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{32'h18000100, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{32'h01000000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{32'h18FFFF00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{32'h02000000, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{32'h18000000, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{32'h01000000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{32'h18000000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{32'h18000100, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{32'h01000000, 16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{32'h18000000, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{32'h03000000, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{32'h05ABCDEF, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{32'h18FFFF00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{32'h04000000, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{32'h05000000, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{32'h7E000000, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{32'h00123456, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      run_instr(tbl[i].word, acc_ack);
      model_step(tbl[i].word);
      check($sformatf("vec%0d acc@ack", i), acc_ack, tbl[i].exp_acc);
      check($sformatf("vec%0d breg", i),    breg,    tbl[i].exp_breg);
      check($sformatf("vec%0d zero", i),    zero,    tbl[i].exp_zero);
      check($sformatf("vec%0d carry", i),   carry,   tbl[i].exp_carry);
      check($sformatf("vec%0d illegal", i), illegal, tbl[i].exp_illegal);
      check($sformatf("vec%0d retired", i), retired, i + 1);
    end

    // start held high across five edges must execute INC only once.
    run_instr(32'h18001000, acc_ack);
    model_step(32'h18001000);
    ret_before = m_retired;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; instr = 32'h04FFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_step(32'h04FFFFFF);
    check("held start pulses", pulses, 1);
    check("held start acc", acc, 16'h0011);
    check("held start retired", retired, ret_before + 1);
    compare_all("held");

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 12);
      case (r)
        0, 1, 2, 3, 4, 5: op = 8'(r);
        6, 7, 8, 9:       op = 8'h18;
        10:               op = 8'h02;
        11:               op = 8'h04;
        default: begin
          op = 8'($urandom_range(6, 254));
          if (op == 8'h18) op = 8'h7E;
        end
      endcase
      case ($urandom_range(0, 3))
        0:       imm = 16'h0000;
        1:       imm = 16'hFFFF;
        default: imm = 16'($urandom);
      endcase
      w = {op, imm, 8'($urandom)};
      run_instr(w, acc_ack);
      model_step(w);
      check($sformatf("rand%0d acc@ack", n), acc_ack, m_acc);
      compare_all($sformatf("rand%0d", n));
    end

    run_instr(32'hFF000000, acc_ack);
    model_step(32'hFF000000);
    compare_all("halt");
    pulses = 0;
    @(negedge clk);
    start = 1'b1; instr = 32'h18555500;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
      if (i == 3) begin
        @(negedge clk);
        start = 1'b0;
      end else if (i == 5) begin
        @(negedge clk);
        start = 1'b1;
      end
    end
    check("halted ready pulses", pulses, 0);
    compare_all("after halt");

    // Reset asserted while an instruction sits in EXEC.
    do_reset();
    run_instr(32'h1800AA00, acc_ack);
    model_step(32'h1800AA00);
    run_instr(32'h7E000000, acc_ack);
    model_step(32'h7E000000);
    compare_all("pre-reset");
    @(negedge clk);
    start = 1'b1; instr = 32'h04000000;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("async reset");
    check("async reset ready", ready, 0);
    @(posedge clk); #1;
    check("reset held ready", ready, 0);
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("discarded instr pulses", pulses, 0);
    compare_all("post reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
